fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_fifo_chk.sv | 11 +
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice:
// the decoder-facing packet, the NOP filler and the default reset PC.
package fetch_unit_pkg;

    typedef logic [31:0] INST;

    typedef struct packed {
        INST         inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } FETCH_PACKET;

    localparam INST         NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam FETCH_PACKET EMPTY_PACKET = '{
        inst:  NOP_INST,
        PC:    32'h0000_0000,
        NPC:   32'h0000_0000,
        valid: 1'b0
    };

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake plus the decoder-facing packet/ready pair.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    logic        Imem2proc_valid;
    logic [31:0] Imem2proc_data;
    FETCH_PACKET if_packet;
    logic        decode_ready;

    modport master (
        output proc2Imem_req, proc2Imem_addr, if_packet,
        input  Imem2proc_valid, Imem2proc_data, decode_ready
    );

    modport slave (
        input  proc2Imem_req, proc2Imem_addr, if_packet,
        output Imem2proc_valid, Imem2proc_data, decode_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch queue; head presents a NOP bubble when empty, flush drops
// every entry by snapping the read pointer onto the write pointer.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq,
    input  FETCH_PACKET            enq_data,
    input  logic                   deq,
    input  logic                   flush,
    output FETCH_PACKET            head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            PW     = $clog2(DEPTH);
    localparam int            CW     = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [PW-1:0] ONE_P  = PW'(1);

    FETCH_PACKET   mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          do_enq_s;
    logic          do_deq_s;

    assign full_s   = (count_r == FULL_C);
    assign do_enq_s = enq && !flush;
    assign do_deq_s = deq && !flush && (count_r != ZERO_C);
    assign count    = count_r;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= ZERO_C;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= ZERO_C;
        end else begin
            if (do_enq_s) wr_ptr_r <= wr_ptr_r + ONE_P;
            if (do_deq_s) rd_ptr_r <= rd_ptr_r + ONE_P;
            case ({do_enq_s, do_deq_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clock) begin
        if (do_enq_s && !reset) mem_r[wr_ptr_r] <= enq_data;
    end

    // Head presentation with bubble when empty
    always_comb begin
        head = EMPTY_PACKET;
        if (count_r != ZERO_C) head = mem_r[rd_ptr_r];
        else                   head = EMPTY_PACKET;
    end

    fetch_fifo_chk u_chk (
        .clock (clock),
        .reset (reset),
        .enq   (do_enq_s),
        .full  (full_s)
    );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Property checks for the fetch queue: an enqueue must never land on a full queue.
module fetch_fifo_chk (
    input logic clock,
    input logic reset,
    input logic enq,
    input logic full
);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(enq && full));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding request FSM and memory handshake,
// feeding a small queue that decouples memory latency from decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         redirect_en,
    input  logic [31:0]  redirect_pc,
    input  logic         stop_fetch,
    fetch_unit_if.master bus
);

    localparam int            CW      = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_e;

    fetch_state_e  state_r;
    fetch_state_e  state_nxt_s;
    logic [31:0]   pc_r;
    logic [31:0]   req_pc_r;
    logic [CW-1:0] count_s;
    FETCH_PACKET   head_s;
    FETCH_PACKET   enq_pkt_s;
    logic          issue_s;
    logic          enq_s;
    logic          deq_s;

    // Redirect outranks issue, enqueue and dequeue in the same cycle.
    assign issue_s = !reset && (state_r == S_FETCH) && !stop_fetch && !redirect_en
                     && (count_s < DEPTH_C);
    assign enq_s   = !reset && (state_r == S_WAIT) && bus.Imem2proc_valid && !redirect_en;
    assign deq_s   = !reset && head_s.valid && bus.decode_ready && !redirect_en;

    assign enq_pkt_s = '{inst:  bus.Imem2proc_data,
                         PC:    req_pc_r,
                         NPC:   req_pc_r + 32'd4,
                         valid: 1'b1};

    fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .enq      (enq_s),
        .enq_data (enq_pkt_s),
        .deq      (deq_s),
        .flush    (redirect_en),
        .head     (head_s),
        .count    (count_s)
    );

    // Memory request strobe/address and decoder packet
    always_comb begin
        bus.proc2Imem_req  = 1'b0;
        bus.proc2Imem_addr = 32'h0000_0000;
        bus.if_packet      = EMPTY_PACKET;
        if (issue_s) begin
            bus.proc2Imem_req  = 1'b1;
            bus.proc2Imem_addr = pc_r;
        end else begin
            bus.proc2Imem_req  = 1'b0;
            bus.proc2Imem_addr = 32'h0000_0000;
        end
        if (reset) bus.if_packet = EMPTY_PACKET;
        else       bus.if_packet = head_s;
    end

    // Fetch FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (stop_fetch)   state_nxt_s = S_HALTED;
                else if (issue_s) state_nxt_s = S_WAIT;
                else              state_nxt_s = S_FETCH;
            end
            S_WAIT: begin
                // A response coinciding with a redirect closes the request; nothing left to drain.
                if (bus.Imem2proc_valid) state_nxt_s = stop_fetch ? S_HALTED : S_FETCH;
                else if (redirect_en)    state_nxt_s = S_DRAIN;
                else                     state_nxt_s = S_WAIT;
            end
            S_DRAIN: begin
                if (bus.Imem2proc_valid) state_nxt_s = stop_fetch ? S_HALTED : S_FETCH;
                else                     state_nxt_s = S_DRAIN;
            end
            S_HALTED: state_nxt_s = S_HALTED;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // State, PC and in-flight request address registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= S_FETCH;
            pc_r     <= RESET_PC;
            req_pc_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (redirect_en) pc_r <= word_align(redirect_pc);
            else if (enq_s)  pc_r <= req_pc_r + 32'd4;
            else             pc_r <= pc_r;
            if (issue_s) req_pc_r <= pc_r;
            else         req_pc_r <= req_pc_r;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table, hand sequences for fill,
// halt and reset corners, and a randomized run against a queue-based model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stop_fetch;

    fetch_unit_if bus();

    fetch_unit #(.FQ_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .stop_fetch  (stop_fetch),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        stop;
        logic        vld;
        logic [31:0] data;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        FETCH_PACKET e_pkt;
    } vec_t;

    vec_t tbl[16];

    // reference model state
    FETCH_PACKET fq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_wait;
    bit          m_drop;
    bit          m_halt;

    // memory responder state for the random run
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_dly;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h1357_9BDF;
    endfunction

    function automatic FETCH_PACKET mk_pkt(input logic [31:0] pc, input logic [31:0] inst);
        return '{inst: inst, PC: pc, NPC: pc + 32'd4, valid: 1'b1};
    endfunction

    function automatic vec_t v(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic vld, input logic [31:0] data,
                               input logic e_req, input logic [31:0] e_addr,
                               input FETCH_PACKET e_pkt);
        vec_t r;
        r = '{rst, redir, rpc, 1'b0, vld, data, 1'b1, e_req, e_addr, e_pkt};
        return r;
    endfunction

    // one clock: inputs applied just after the rising edge, outputs sampled 2ns later
    task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic stop, input logic vld, input logic [31:0] data,
                         input logic rdy);
        @(posedge clock);
        #1;
        reset               = rst;
        redirect_en         = redir;
        redirect_pc         = rpc;
        stop_fetch          = stop;
        bus.Imem2proc_valid = vld;
        bus.Imem2proc_data  = data;
        bus.decode_ready    = rdy;
        #2;
    endtask

    task automatic chk_bus(input string name, input logic e_req, input logic [31:0] e_addr);
        checks++;
        if (bus.proc2Imem_req !== e_req || bus.proc2Imem_addr !== e_addr) begin
            failures++;
            $display("FAIL %s: req=%0b addr=%h, expected req=%0b addr=%h at %0t",
                     name, bus.proc2Imem_req, bus.proc2Imem_addr, e_req, e_addr, $time);
        end
    endtask

    task automatic chk_pkt(input string name, input FETCH_PACKET e);
        checks++;
        if (bus.if_packet !== e) begin
            failures++;
            $display("FAIL %s: pkt v=%0b pc=%h npc=%h inst=%h, expected v=%0b pc=%h npc=%h inst=%h at %0t",
                     name, bus.if_packet.valid, bus.if_packet.PC, bus.if_packet.NPC, bus.if_packet.inst,
                     e.valid, e.PC, e.NPC, e.inst, $time);
        end
    endtask

    // request in this cycle, response (k=1) in the next
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic rdy,
                             input logic stop);
        cycle(1'b0, 1'b0, 32'h0, stop, 1'b0, 32'h0, rdy);
        chk_bus({tag, "_req"}, 1'b1, addr);
        cycle(1'b0, 1'b0, 32'h0, stop, 1'b1, inst_of(addr), rdy);
        chk_bus({tag, "_rsp"}, 1'b0, 32'h0);
    endtask

    function automatic bit model_req();
        return !reset && !m_halt && !m_wait && !m_drop && !stop_fetch && !redirect_en
               && (fq.size() < DEPTH);
    endfunction

    function automatic FETCH_PACKET model_pkt();
        if (reset || fq.size() == 0) return EMPTY_PACKET;
        return fq[0];
    endfunction

    // advance the model across the rising edge using the inputs now applied
    task automatic model_step(input bit issued);
        bit          idle;
        bit          resp;
        logic [31:0] pc_old;
        if (reset) begin
            fq.delete();
            m_pc = 32'h0000_0000; m_req_pc = 32'h0;
            m_wait = 1'b0; m_drop = 1'b0; m_halt = 1'b0;
        end else begin
            idle   = !m_halt && !m_wait && !m_drop;
            resp   = bus.Imem2proc_valid && (m_wait || m_drop);
            pc_old = m_pc;
            if (redirect_en) begin
                fq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (fq.size() > 0 && bus.decode_ready) void'(fq.pop_front());
                if (m_wait && bus.Imem2proc_valid) begin
                    fq.push_back(mk_pkt(m_req_pc, bus.Imem2proc_data));
                    m_pc = m_req_pc + 32'd4;
                end
            end
            if (resp) begin
                m_wait = 1'b0; m_drop = 1'b0;
                if (stop_fetch) m_halt = 1'b1;
            end else if (m_wait && redirect_en) begin
                m_wait = 1'b0; m_drop = 1'b1;
            end
            if (issued) begin
                m_wait = 1'b1; m_req_pc = pc_old;
            end
            if (idle && stop_fetch) m_halt = 1'b1;
        end
    endtask

    initial begin
        logic        r_rst, r_redir, r_stop, r_vld, r_rdy, e_req;
        logic [31:0] r_rpc, r_data;

        // k=2 fetch stream, then redirect in WAIT and redirect coinciding with a response
        tbl[0]  = v(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0,   EMPTY_PACKET);
        tbl[1]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0,   EMPTY_PACKET);
        tbl[2]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0,   EMPTY_PACKET);
        tbl[3]  = v(1'b0, 1'b0, 32'h0,   1'b1, inst_of(32'h0), 1'b0, 32'h0,  EMPTY_PACKET);
        tbl[4]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h4,   mk_pkt(32'h0, inst_of(32'h0)));
        tbl[5]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0,   EMPTY_PACKET);
        tbl[6]  = v(1'b0, 1'b0, 32'h0,   1'b1, inst_of(32'h4), 1'b0, 32'h0,  EMPTY_PACKET);
        tbl[7]  = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h8,   mk_pkt(32'h4, inst_of(32'h4)));
        tbl[8]  = v(1'b0, 1'b1, 32'h103, 1'b0, 32'h0,         1'b0, 32'h0,   EMPTY_PACKET);
        tbl[9]  = v(1'b0, 1'b0, 32'h0,   1'b1, 32'hBAD0_0008, 1'b0, 32'h0,   EMPTY_PACKET);
        tbl[10] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h100, EMPTY_PACKET);
        tbl[11] = v(1'b0, 1'b1, 32'h200, 1'b1, 32'hBAD0_0100, 1'b0, 32'h0,   EMPTY_PACKET);
        tbl[12] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h200, EMPTY_PACKET);
        tbl[13] = v(1'b0, 1'b0, 32'h0,   1'b1, inst_of(32'h200), 1'b0, 32'h0, EMPTY_PACKET);
        tbl[14] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h204, mk_pkt(32'h200, inst_of(32'h200)));
        tbl[15] = v(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0,   EMPTY_PACKET);

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].stop, tbl[i].vld, tbl[i].data, tbl[i].rdy);
            chk_bus($sformatf("tbl%0d_bus", i), tbl[i].e_req, tbl[i].e_addr);
            chk_pkt($sformatf("tbl%0d_pkt", i), tbl[i].e_pkt);
        end

        // queue fills with decode stalled; one dequeue frees a slot for 0x10
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_bus("fill_rst_bus", 1'b0, 32'h0);
        chk_pkt("fill_rst_pkt", EMPTY_PACKET);
        for (int i = 0; i < 4; i++) fetch_one($sformatf("fill%0d", i), 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_bus("full_noreq", 1'b0, 32'h0);
        chk_pkt("full_head", mk_pkt(32'h0, inst_of(32'h0)));
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_bus("full_deq_cycle", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_bus("after_deq_req", 1'b1, 32'h10);
        chk_pkt("after_deq_head", mk_pkt(32'h4, inst_of(32'h4)));

        // stop during WAIT: the in-flight word still lands, then nothing more is fetched
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch_one("h0", 32'h0, 1'b0, 1'b0);
        fetch_one("h4", 32'h4, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_bus("h_req8", 1'b1, 32'h8);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_bus("h_wait", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, inst_of(32'h8), 1'b0);
        chk_bus("h_rsp8", 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            chk_bus($sformatf("halt_drain%0d_bus", i), 1'b0, 32'h0);
            chk_pkt($sformatf("halt_drain%0d_pkt", i), mk_pkt(32'(4 * i), inst_of(32'(4 * i))));
        end
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        chk_bus("halt_redir", 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk_bus($sformatf("halt_stays%0d", i), 1'b0, 32'h0);
            chk_pkt($sformatf("halt_empty%0d", i), EMPTY_PACKET);
        end

        // reset while WAIT, late response the cycle after must be ignored
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_bus("r_req0", 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_bus("r_in_reset", 1'b0, 32'h0);
        chk_pkt("r_in_reset_pkt", EMPTY_PACKET);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk_bus("r_reissue", 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_pkt("r_late_dropped", EMPTY_PACKET);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, inst_of(32'h0), 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_pkt("r_first_pkt", mk_pkt(32'h0, inst_of(32'h0)));
        chk_bus("r_next", 1'b1, 32'h4);

        // randomized traffic against the model, memory latency 1..3
        for (int seg = 0; seg < 4; seg++) begin
            r_stop   = 1'b0;
            mem_pend = 1'b0;
            for (int c = 0; c < 400; c++) begin
                r_rst   = (c == 0);
                r_redir = ($urandom_range(0, 19) == 0);
                r_rpc   = $urandom & 32'h0000_0FFF;
                if (!r_rst && $urandom_range(0, 299) == 0) r_stop = 1'b1;
                r_rdy   = ($urandom_range(0, 3) < ((seg == 1) ? 1 : 3));
                r_vld   = 1'b0;
                r_data  = 32'h0;
                if (r_rst) begin
                    mem_pend = 1'b0;
                end else if (mem_pend) begin
                    mem_dly--;
                    if (mem_dly == 0) begin
                        r_vld    = 1'b1;
                        r_data   = inst_of(mem_addr);
                        mem_pend = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    r_vld  = 1'b1;
                    r_data = $urandom;
                end
                cycle(r_rst, r_redir, r_rpc, r_stop, r_vld, r_data, r_rdy);
                e_req = model_req();
                chk_bus("rnd_bus", e_req, e_req ? m_pc : 32'h0);
                chk_pkt("rnd_pkt", model_pkt());
                model_step(e_req);
                if (!r_rst && bus.proc2Imem_req) begin
                    mem_pend = 1'b1;
                    mem_addr = bus.proc2Imem_addr;
                    mem_dly  = $urandom_range(1, 3);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
